// File: rtl/uart_prog_pkg.sv
// uart_prog_pkg: shared types and constants for the UART boot loader.
package uart_prog_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic REGION_INST = 1'b0;
    localparam logic REGION_DATA = 1'b1;
    localparam int ADR_W = 15;
    localparam int IDX_W = 14;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchroniser, mid-bit sampling and frame-error flag.
module uart_rx
    import uart_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bits, bits_n;
    logic [7:0] data_n;
    logic s1, s2, s3, valid_n, ferr_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {s1, s2, s3} <= 3'b111;
            state <= R_IDLE;
            cnt <= '0;
            bits <= '0;
            data <= '0;
            byte_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            {s1, s2, s3} <= {rx, s1, s2};
            state <= state_n;
            cnt <= cnt_n;
            bits <= bits_n;
            data <= data_n;
            byte_valid <= valid_n;
            frame_err <= ferr_n;
        end
    end

    // s3 is the previous synchronised value, so only a genuine high-to-low edge starts a frame
    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        bits_n = bits;
        data_n = data;
        valid_n = 1'b0;
        ferr_n = 1'b0;
        case (state)
            R_IDLE: begin
                cnt_n = '0;
                if (s3 && !s2) state_n = R_START;
            end
            R_START: if (cnt == HALF) begin
                cnt_n = '0;
                bits_n = '0;
                state_n = s2 ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt == FULL) begin
                cnt_n = '0;
                data_n = {s2, data[7:1]};
                bits_n = bits + 1'b1;
                if (bits == 3'd7) state_n = R_STOP;
            end
            R_STOP: if (cnt == FULL) begin
                state_n = R_IDLE;
                valid_n = s2;
                ferr_n = !s2;
            end
            default: state_n = R_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_programmer.sv
// uart_programmer: loads a length-prefixed instruction image then data image from UART
// into memory via single-cycle upg_* word writes.
module uart_programmer
    import uart_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int MAX_WORDS = 16384,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_i,
    output logic             upg_clk_o,
    output logic             upg_wen_o,
    output logic [ADR_W-1:0] upg_adr_o,
    output logic [31:0]      upg_dat_o,
    output logic             upg_done_o,
    output logic             upg_err_o,
    output logic             busy_o
);
    state_t state, state_n, end_state;
    logic reg_sel, reg_sel_n, byte_valid, frame_err, last;
    logic [7:0] rx_data;
    logic [15:0] len, len_n, n_cnt;
    logic [IDX_W-1:0] idx, idx_n;
    logic [1:0] bcnt, bcnt_n;
    logic [31:0] word, word_n, dat_n;
    logic [ADR_W-1:0] adr_n;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk(clk),
        .rst(rst),
        .rx(rx_i),
        .byte_valid(byte_valid),
        .data(rx_data),
        .frame_err(frame_err)
    );

    assign upg_clk_o = clk;
    assign upg_wen_o = state == S_WRITE;
    assign upg_done_o = state == S_DONE;
    assign upg_err_o = state == S_ERR;
    assign busy_o = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE};
    assign n_cnt = {rx_data, len[7:0]};
    assign last = 16'(idx) + 16'd1 == len;
    assign end_state = reg_sel == REGION_DATA ? S_DONE : S_LEN_LO;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            reg_sel <= REGION_INST;
            len <= '0;
            idx <= '0;
            bcnt <= '0;
            word <= '0;
            upg_adr_o <= '0;
            upg_dat_o <= '0;
        end else begin
            state <= state_n;
            reg_sel <= reg_sel_n;
            len <= len_n;
            idx <= idx_n;
            bcnt <= bcnt_n;
            word <= word_n;
            upg_adr_o <= adr_n;
            upg_dat_o <= dat_n;
        end
    end

    // Finishing a region always leaves reg_sel at DATA: from INST it advances, from DATA it stays.
    always_comb begin
        state_n = state;
        reg_sel_n = reg_sel;
        len_n = len;
        idx_n = idx;
        bcnt_n = bcnt;
        word_n = word;
        adr_n = upg_adr_o;
        dat_n = upg_dat_o;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (byte_valid && rx_data == SYNC_BYTE) begin
                state_n = S_LEN_LO;
                reg_sel_n = REGION_INST;
            end
            S_LEN_LO: if (frame_err) state_n = S_ERR;
                else if (byte_valid) begin
                    len_n[7:0] = rx_data;
                    state_n = S_LEN_HI;
                end
            S_LEN_HI: if (frame_err) state_n = S_ERR;
                else if (byte_valid) begin
                    len_n[15:8] = rx_data;
                    idx_n = '0;
                    bcnt_n = '0;
                    reg_sel_n = n_cnt == 16'd0 ? REGION_DATA : reg_sel;
                    state_n = n_cnt > 16'(MAX_WORDS) ? S_ERR : n_cnt == 16'd0 ? end_state : S_DATA;
                end
            S_DATA: if (frame_err) state_n = S_ERR;
                else if (byte_valid) begin
                    word_n = {rx_data, word[31:8]};
                    bcnt_n = bcnt + 1'b1;
                    if (bcnt == 2'd3) begin
                        adr_n = {reg_sel, idx};
                        dat_n = {rx_data, word[31:8]};
                        state_n = S_WRITE;
                    end
                end
            S_WRITE: begin
                idx_n = idx + 1'b1;
                reg_sel_n = last ? REGION_DATA : reg_sel;
                state_n = last ? end_state : S_DATA;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_programmer.sv
// tb_uart_programmer: drives UART frames into uart_programmer and checks writes against an image model.
module tb_uart_programmer;
    localparam int CPB = 16;

    logic clk = 1'b0, rst = 1'b0, rx = 1'b1;
    logic upg_clk_o, upg_wen_o, upg_done_o, upg_err_o, busy_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;

    uart_programmer #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .rx_i(rx),
        .upg_clk_o(upg_clk_o),
        .upg_wen_o(upg_wen_o),
        .upg_adr_o(upg_adr_o),
        .upg_dat_o(upg_dat_o),
        .upg_done_o(upg_done_o),
        .upg_err_o(upg_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [14:0] got_adr[$];
    logic [31:0] got_dat[$];
    int got_cyc[$];
    int wide = 0;
    logic prev_wen = 1'b0;
    always @(negedge clk) begin
        if (upg_wen_o) begin
            got_adr.push_back(upg_adr_o);
            got_dat.push_back(upg_dat_o);
            got_cyc.push_back(cyc);
        end
        if (upg_wen_o && prev_wen) wide++;
        prev_wen = upg_wen_o;
    end

    int checks = 0, errors = 0, last_edge = 0;
    logic [31:0] img_i[$], img_d[$];

    task automatic clear_log();
        got_adr.delete();
        got_dat.delete();
        got_cyc.delete();
        wide = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
        @(negedge clk);
        last_edge = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Reference: the image is written region by region, word by word, adr = {region, index}.
    task automatic run_image(input string name, input int gap);
        logic [14:0] ea[$];
        logic [31:0] ed[$];
        int ee[$];
        logic [31:0] w;
        clear_log();
        send_byte(8'hA5, 1'b1, gap);
        for (int r = 0; r < 2; r++) begin
            int n = (r == 1) ? img_d.size() : img_i.size();
            send_byte(n[7:0], 1'b1, gap);
            send_byte(n[15:8], 1'b1, gap);
            for (int j = 0; j < n; j++) begin
                w = (r == 1) ? img_d[j] : img_i[j];
                for (int k = 0; k < 4; k++) send_byte(w[8*k+:8], 1'b1, gap);
                ea.push_back({r[0], j[13:0]});
                ed.push_back(w);
                ee.push_back(last_edge);
            end
        end
        repeat (40) @(negedge clk);
        checks++;
        if (got_adr.size() != ea.size()) begin
            errors++;
            $display("FAIL %s write_count got %0d exp %0d", name, got_adr.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < got_adr.size(); i++) begin
            checks++;
            if (got_adr[i] !== ea[i] || got_dat[i] !== ed[i]) begin
                errors++;
                $display("FAIL %s write%0d got %h/%h exp %h/%h", name, i, got_adr[i], got_dat[i], ea[i], ed[i]);
            end
            checks++;
            if (got_cyc[i] - ee[i] < 9 * CPB || got_cyc[i] - ee[i] >= 11 * CPB) begin
                errors++;
                $display("FAIL %s latency%0d got %0d exp in [%0d,%0d)", name, i, got_cyc[i] - ee[i], 9 * CPB, 11 * CPB);
            end
        end
        checks++;
        if ({upg_done_o, upg_err_o, busy_o, wide} !== {3'b100, 32'd0}) begin
            errors++;
            $display("FAIL %s final done/err/busy/wide got %b%b%b/%0d exp 100/0", name, upg_done_o, upg_err_o, busy_o, wide);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b %h %h %b%b%b exp all 0", upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o, busy_o);
        end
        rst = 1'b1;
        clear_log();
        repeat (1000) @(negedge clk);
        checks++;
        if (got_adr.size() != 0 || {upg_adr_o, upg_dat_o, upg_done_o, upg_err_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL idle_line writes got %0d outputs %h %h %b%b%b exp 0", got_adr.size(), upg_adr_o, upg_dat_o, upg_done_o, upg_err_o, busy_o);
        end
        @(posedge clk) #1;
        checks++;
        if (upg_clk_o !== 1'b1) begin
            errors++;
            $display("FAIL upg_clk got %b exp 1", upg_clk_o);
        end
    endtask

    task automatic test_example();
        img_i = '{32'h44332211, 32'h88776655};
        img_d = '{32'hDEADBEEF};
        run_image("example", CPB);
    endtask

    task automatic test_empty();
        img_i.delete();
        img_d.delete();
        run_image("empty", CPB);
    endtask

    task automatic test_too_long();
        clear_log();
        send_byte(8'hA5, 1'b1, CPB);
        send_byte(8'h01, 1'b1, CPB);
        send_byte(8'h40, 1'b1, CPB);
        repeat (20) @(negedge clk);
        checks++;
        if ({upg_err_o, upg_done_o, busy_o} !== 3'b100 || got_adr.size() != 0) begin
            errors++;
            $display("FAIL too_long err/done/busy got %b%b%b writes %0d exp 100 writes 0", upg_err_o, upg_done_o, busy_o, got_adr.size());
        end
        img_i.delete();
        img_d.delete();
        run_image("recover", CPB);
    endtask

    task automatic test_frame_err();
        clear_log();
        send_byte(8'h12, 1'b1, CPB);
        send_byte(8'h34, 1'b1, CPB);
        checks++;
        if ({upg_done_o, busy_o} !== 2'b10) begin
            errors++;
            $display("FAIL garbage_ignored done/busy got %b%b exp 10", upg_done_o, busy_o);
        end
        send_byte(8'hA5, 1'b1, CPB);
        checks++;
        if ({upg_done_o, busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL sync_busy done/busy got %b%b exp 01", upg_done_o, busy_o);
        end
        send_byte(8'h01, 1'b1, CPB);
        send_byte(8'h00, 1'b1, CPB);
        send_byte(8'h11, 1'b1, CPB);
        send_byte(8'h22, 1'b1, CPB);
        send_byte(8'h33, 1'b0, CPB);
        send_byte(8'h44, 1'b1, CPB);
        repeat (20) @(negedge clk);
        checks++;
        if ({upg_err_o, upg_done_o, busy_o} !== 3'b100 || got_adr.size() != 0) begin
            errors++;
            $display("FAIL frame_err err/done/busy got %b%b%b writes %0d exp 100 writes 0", upg_err_o, upg_done_o, busy_o, got_adr.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_byte(8'hA5, 1'b1, CPB);
        send_byte(8'h01, 1'b1, CPB);
        send_byte(8'h00, 1'b1, CPB);
        send_byte(8'h11, 1'b1, CPB);
        send_byte(8'h22, 1'b1, CPB);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b %h %h %b%b%b exp all 0", upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o, busy_o);
        end
        rst = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (got_adr.size() != 0 || {upg_done_o, upg_err_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_idle writes %0d done/err/busy %b%b%b exp 0 000", got_adr.size(), upg_done_o, upg_err_o, busy_o);
        end
        img_i = '{$urandom, $urandom};
        img_d = '{$urandom};
        run_image("after_reset", CPB);
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 4; it++) begin
            logic [31:0] w;
            img_i.delete();
            img_d.delete();
            for (int j = $urandom_range(0, 3); j > 0; j--) begin
                w = $urandom;
                if ($urandom_range(0, 2) == 0) w[7:0] = 8'hA5;
                img_i.push_back(w);
            end
            for (int j = $urandom_range(0, 3); j > 0; j--) img_d.push_back($urandom);
            run_image($sformatf("random%0d", it), (it == 0) ? 0 : int'($urandom_range(0, 20)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_example();
        test_empty();
        test_too_long();
        test_frame_err();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
